pps_duty_ctrl: RTL and testbench
================================

PPS_DUTY_CTRL -- requirements
Module: pps_duty_ctrl

Interface
REQ-001 SHALL have parameter F_NOMINAL, 10000000, expected CLK_SYS cycles per PPS period.
REQ-002 SHALL have parameter GAIN, 1, unsigned integer loop gain applied to the period error.
REQ-003 SHALL have parameter DUTY_INIT, 32768, duty value after reset.
REQ-004 SHALL have parameters DUTY_MIN, 1, and DUTY_MAX, 65534, as inclusive duty saturation limits.
REQ-005 SHALL have parameter ERR_LIMIT, 1000, maximum |error| accepted as a valid measurement.
REQ-006 SHALL have parameters LOCK_TOL, 2, and LOCK_CNT, 8, for lock detection (|error| tolerance; consecutive seconds).
REQ-007 SHALL have port CLK_SYS, input, 1, the single system clock.
REQ-008 SHALL have port CLK_RST, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port PPS_In, input, 1, asynchronous GPS 1PPS.
REQ-010 SHALL have port PWM_Duty, output, 32, duty word for the downstream PWM stage.
REQ-011 SHALL have port Duty_Valid, output, 1, one-cycle pulse when PWM_Duty changes or is re-issued.
REQ-012 SHALL have port Err_Out, output, 32, signed last period error (captured − F_NOMINAL).
REQ-013 SHALL have port Lock, output, 1, loop-locked flag.
REQ-014 SHALL have port Holdover, output, 1, PPS-lost flag.

Function
REQ-015 SHALL synchronise PPS_In through two flops and detect its rising edge in the third cycle (edge cycle E).
REQ-016 SHALL run a 32-bit period counter: at E capture counter+1, then clear it to 0; otherwise increment, saturating at all-ones.
REQ-017 SHALL use states IDLE, MEASURE, UPDATE and HOLDOVER; reset enters IDLE.
REQ-018 IDLE: the first edge starts counting and moves to MEASURE, with no capture used and no update.
REQ-019 MEASURE: at an edge, capture the period and go to UPDATE.
REQ-020 UPDATE: compute error at E+1; at E+2 drive PWM_Duty, Err_Out and Duty_Valid; then return to MEASURE.
REQ-021 SHALL compute duty_new = PWM_Duty − error×GAIN in at least 48-bit signed arithmetic, saturated to [DUTY_MIN, DUTY_MAX].
REQ-022 If |error| > ERR_LIMIT: update Err_Out, hold PWM_Duty, suppress Duty_Valid, and clear the lock counter.
REQ-023 On an accepted update with |error| ≤ LOCK_TOL, the lock counter SHALL increment, saturating at LOCK_CNT; any other accepted update SHALL clear it.
REQ-024 Lock SHALL be 1 exactly when the lock counter equals LOCK_CNT.
REQ-025 An edge arriving during UPDATE SHALL still be captured for the next period; no edge is lost.

Reset
REQ-026 On CLK_RST low: PWM_Duty=DUTY_INIT, Duty_Valid=0, Err_Out=0, Lock=0, Holdover=0, counter=0, lock counter=0, state IDLE.
REQ-027 Reset asserted mid-measurement SHALL discard the partial period; the first post-reset edge behaves as IDLE.

Configuration
REQ-028 With PPS_HOLDOVER_EN defined: counter reaching 2×F_NOMINAL without an edge SHALL enter HOLDOVER (Holdover=1, Lock=0, lock counter cleared, PWM_Duty frozen).
REQ-029 HOLDOVER: the next edge SHALL clear Holdover, restart counting and move to MEASURE without an update, as in IDLE.
REQ-030 Without PPS_HOLDOVER_EN: HOLDOVER SHALL be unreachable, Holdover SHALL be tied 0, and a long gap SHALL be rejected by ERR_LIMIT.

Structure
REQ-031 Package gpsdo_pkg SHALL hold the state enum, DUTY_W=32, CNT_W=32 and the F_NOMINAL default.
REQ-032 Synchroniser and edge detector SHALL be sub-module pps_sync.

Verification
All scenarios use F_NOMINAL=1000, GAIN=4, DUTY_INIT=32768, ERR_LIMIT=100, LOCK_CNT=4, LOCK_TOL=2, PPS_HOLDOVER_EN defined unless stated.
REQ-033 PPS period 1000 cycles ×6 → Err_Out=0, PWM_Duty=32768, Duty_Valid pulse at E+2 each second, Lock=1 after the 4th update.
REQ-034 Period 1003 → Err_Out=+3, PWM_Duty=32756; period 997 → Err_Out=−3, PWM_Duty back to 32768.
REQ-035 DUTY_INIT=65530, period 990 → Err_Out=−10, PWM_Duty clamped to 65534.
REQ-036 While locked, period 1500 → Err_Out=+500, no Duty_Valid, PWM_Duty unchanged, Lock=0.
REQ-037 PPS stopped → Holdover=1 at 2000 cycles after the last edge; the next edge gives no update, and the following 1000-cycle period updates normally.
REQ-038 Reset pulsed 400 cycles into a period → all outputs at reset values; the first edge after reset causes no Duty_Valid.

Source files
------------

// File: rtl/gpsdo_pkg.sv
// Shared types and sizing for the GPS-disciplined duty controller.
package gpsdo_pkg;
  localparam int unsigned DUTY_W        = 32;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned F_NOMINAL_DEF = 32'd10000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    UPDATE   = 2'd2,
    HOLDOVER = 2'd3
  } state_e;

  function automatic logic [63:0] abs64(input logic signed [63:0] v);
    if (v < 64'sd0) begin
      return 64'(-v);
    end else begin
      return 64'(v);
    end
  endfunction
endpackage

// File: rtl/pps_sync.sv
// Two-flop synchroniser for the asynchronous 1PPS input plus rising-edge detector.
module pps_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pps_i,
  output logic edge_o
);
  logic [1:0] sync_q;
  logic       dly_q;

  // Synchroniser chain and one-cycle delay for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pps_i};
      dly_q  <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] & ~dly_q;
endmodule

// File: rtl/pps_duty_ctrl.sv
// Measures the 1PPS period in system clocks and steers a PWM duty word against it.
// Define PPS_HOLDOVER_EN to enable entry into HOLDOVER when PPS disappears.
module pps_duty_ctrl
  import gpsdo_pkg::*;
#(
  parameter int unsigned F_NOMINAL = F_NOMINAL_DEF,
  parameter int unsigned GAIN      = 32'd1,
  parameter int unsigned DUTY_INIT = 32'd32768,
  parameter int unsigned DUTY_MIN  = 32'd1,
  parameter int unsigned DUTY_MAX  = 32'd65534,
  parameter int unsigned ERR_LIMIT = 32'd1000,
  parameter int unsigned LOCK_TOL  = 32'd2,
  parameter int unsigned LOCK_CNT  = 32'd8
) (
  input  logic                     CLK_SYS,
  input  logic                     CLK_RST,
  input  logic                     PPS_In,
  output logic [DUTY_W-1:0]        PWM_Duty,
  output logic                     Duty_Valid,
  output logic signed [31:0]       Err_Out,
  output logic                     Lock,
  output logic                     Holdover
);
  logic              edge_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cap_q, cap_d, cnt_inc_s;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic signed [31:0] err_q, err_d;
  logic [31:0]       lock_cnt_q, lock_cnt_d;
  logic              lock_q, lock_d;
  logic              hold_q, hold_d;
  logic signed [63:0] err_s, duty_new_s;
  logic [63:0]       err_abs_s;
  logic              hold_trip_s;

  pps_sync u_sync (
    .clk_i  (CLK_SYS),
    .rst_ni (CLK_RST),
    .pps_i  (PPS_In),
    .edge_o (edge_s)
  );

  // Period counter: saturating increment, cleared on every edge
  always_comb begin
    cnt_inc_s = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (edge_s) begin
      cnt_d = '0;
      cap_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_inc_s;
      cap_d = cap_q;
    end
  end

  assign err_s      = $signed({32'd0, cap_q}) - $signed(64'(F_NOMINAL));
  assign err_abs_s  = abs64(err_s);
  assign duty_new_s = $signed({32'd0, duty_q}) - err_s * $signed(64'(GAIN));

`ifdef PPS_HOLDOVER_EN
  assign hold_trip_s = (cnt_q >= CNT_W'(32'd2 * F_NOMINAL));
`else
  assign hold_trip_s = 1'b0;
`endif

  // Control FSM: next state, duty update, error reporting and lock tracking
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    lock_cnt_d = lock_cnt_q;
    hold_d     = hold_q;
    case (state_q)
      IDLE: begin
        if (edge_s) begin
          state_d = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (edge_s) begin
          state_d = UPDATE;
        end else if (hold_trip_s) begin
          state_d    = HOLDOVER;
          hold_d     = 1'b1;
          lock_cnt_d = 32'd0;
        end else begin
          state_d = MEASURE;
        end
      end
      UPDATE: begin
        err_d   = err_s[31:0];
        state_d = edge_s ? UPDATE : MEASURE;
        if (err_abs_s > 64'(ERR_LIMIT)) begin
          lock_cnt_d = 32'd0;
        end else begin
          valid_d = 1'b1;
          if (duty_new_s < $signed(64'(DUTY_MIN))) begin
            duty_d = DUTY_W'(DUTY_MIN);
          end else if (duty_new_s > $signed(64'(DUTY_MAX))) begin
            duty_d = DUTY_W'(DUTY_MAX);
          end else begin
            duty_d = duty_new_s[DUTY_W-1:0];
          end
          if (err_abs_s > 64'(LOCK_TOL)) begin
            lock_cnt_d = 32'd0;
          end else if (lock_cnt_q < LOCK_CNT) begin
            lock_cnt_d = lock_cnt_q + 32'd1;
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end
      end
      HOLDOVER: begin
        if (edge_s) begin
          state_d = MEASURE;
          hold_d  = 1'b0;
        end else begin
          state_d = HOLDOVER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    lock_d = (lock_cnt_d == LOCK_CNT);
  end

  // State and output registers
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      duty_q     <= DUTY_W'(DUTY_INIT);
      valid_q    <= 1'b0;
      err_q      <= 32'sd0;
      lock_cnt_q <= 32'd0;
      lock_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
    end
  end

  assign PWM_Duty   = duty_q;
  assign Duty_Valid = valid_q;
  assign Err_Out    = err_q;
  assign Lock       = lock_q;
  assign Holdover   = hold_q;
endmodule

// File: tb/tb_pps_duty_ctrl.sv
// Directed, table-driven bench for pps_duty_ctrl (two instances: nominal and near-max initial duty).
module tb_pps_duty_ctrl;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               pps;
  logic [31:0]        duty1, duty2;
  logic               valid1, valid2;
  logic signed [31:0] err1, err2;
  logic               lock1, lock2, hold1, hold2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pps_duty_ctrl #(
    .F_NOMINAL(1000), .GAIN(4), .DUTY_INIT(32768), .DUTY_MIN(1), .DUTY_MAX(65534),
    .ERR_LIMIT(100), .LOCK_TOL(2), .LOCK_CNT(4)
  ) dut (
    .CLK_SYS(clk), .CLK_RST(rst_n), .PPS_In(pps),
    .PWM_Duty(duty1), .Duty_Valid(valid1), .Err_Out(err1), .Lock(lock1), .Holdover(hold1)
  );

  pps_duty_ctrl #(
    .F_NOMINAL(1000), .GAIN(4), .DUTY_INIT(65530), .DUTY_MIN(1), .DUTY_MAX(65534),
    .ERR_LIMIT(100), .LOCK_TOL(2), .LOCK_CNT(4)
  ) dut_hi (
    .CLK_SYS(clk), .CLK_RST(rst_n), .PPS_In(pps),
    .PWM_Duty(duty2), .Duty_Valid(valid2), .Err_Out(err2), .Lock(lock2), .Holdover(hold2)
  );

  typedef struct {
    int len;
    bit exp_valid;
    int exp_err;
    int exp_duty;
    int exp_duty2;
    bit exp_lock;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One PPS rising edge at the current negedge, then len clock periods until the next one.
  task automatic run_window(input int len, output int nvalid, output int vidx);
    nvalid = 0;
    vidx   = -1;
    pps    = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == 5) pps = 1'b0;
      if (valid1 === 1'b1) begin
        nvalid++;
        if (vidx < 0) vidx = i;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty"},  duty1, 32768);
    check({tag, "_duty2"}, duty2, 65530);
    check({tag, "_valid"}, valid1, 0);
    check({tag, "_err"},   err1, 0);
    check({tag, "_lock"},  lock1, 0);
    check({tag, "_hold"},  hold1, 0);
  endtask

  initial begin
    int nv, vi;
    // len, valid, err, duty, duty(hi instance), lock -- outputs reflect the edge starting each window
    vecs[0]  = '{1000, 1'b0,    0, 32768, 65530, 1'b0};
    vecs[1]  = '{1000, 1'b1,    0, 32768, 65530, 1'b0};
    vecs[2]  = '{1000, 1'b1,    0, 32768, 65530, 1'b0};
    vecs[3]  = '{1000, 1'b1,    0, 32768, 65530, 1'b0};
    vecs[4]  = '{1000, 1'b1,    0, 32768, 65530, 1'b1};
    vecs[5]  = '{1003, 1'b1,    0, 32768, 65530, 1'b1};
    vecs[6]  = '{ 997, 1'b1,    3, 32756, 65518, 1'b0};
    vecs[7]  = '{ 990, 1'b1,   -3, 32768, 65530, 1'b0};
    vecs[8]  = '{1010, 1'b1,  -10, 32808, 65534, 1'b0};
    vecs[9]  = '{1001, 1'b1,   10, 32768, 65494, 1'b0};
    vecs[10] = '{ 999, 1'b1,    1, 32764, 65490, 1'b0};
    vecs[11] = '{1000, 1'b1,   -1, 32768, 65494, 1'b0};
    vecs[12] = '{1000, 1'b1,    0, 32768, 65494, 1'b0};
    vecs[13] = '{1500, 1'b1,    0, 32768, 65494, 1'b1};
    vecs[14] = '{1100, 1'b0,  500, 32768, 65494, 1'b0};
    vecs[15] = '{ 899, 1'b1,  100, 32368, 65094, 1'b0};
    vecs[16] = '{1002, 1'b0, -101, 32368, 65094, 1'b0};
    vecs[17] = '{1000, 1'b1,    2, 32360, 65086, 1'b0};
    vecs[18] = '{1000, 1'b1,    0, 32360, 65086, 1'b0};
    vecs[19] = '{1000, 1'b1,    0, 32360, 65086, 1'b0};
    vecs[20] = '{1000, 1'b1,    0, 32360, 65086, 1'b1};

    pps   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      run_window(vecs[i].len, nv, vi);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_valid_cnt", i), nv, 1);
        check($sformatf("v%0d_valid_lat", i), vi, 4);
      end else begin
        check($sformatf("v%0d_valid_cnt", i), nv, 0);
      end
      check($sformatf("v%0d_err", i),   err1,  vecs[i].exp_err);
      check($sformatf("v%0d_duty", i),  duty1, vecs[i].exp_duty);
      check($sformatf("v%0d_duty2", i), duty2, vecs[i].exp_duty2);
      check($sformatf("v%0d_lock", i),  lock1, vecs[i].exp_lock);
      check($sformatf("v%0d_hold", i),  hold1, 0);
    end

    // PPS stops: total gap of 2010 cycles after the last edge
    repeat (990) @(negedge clk);
    check("gap1990_hold", hold1, 0);
    repeat (20) @(negedge clk);
`ifdef PPS_HOLDOVER_EN
    check("gap2010_hold", hold1, 1);
    check("gap2010_lock", lock1, 0);
`else
    check("gap2010_hold", hold1, 0);
    check("gap2010_lock", lock1, 1);
`endif
    run_window(1000, nv, vi);
    check("resume_valid_cnt", nv, 0);
    check("resume_hold", hold1, 0);
    check("resume_lock", lock1, 0);
    check("resume_duty", duty1, 32360);
`ifdef PPS_HOLDOVER_EN
    check("resume_err", err1, 0);
`else
    check("resume_err", err1, 1010);
`endif
    run_window(1000, nv, vi);
    check("after_resume_valid_cnt", nv, 1);
    check("after_resume_valid_lat", vi, 4);
    check("after_resume_err", err1, 0);
    check("after_resume_duty", duty1, 32360);
    check("after_resume_lock", lock1, 0);

    // Reset pulsed 400 cycles into a period
    pps = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 5) pps = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("midreset");
    rst_n = 1'b1;
    repeat (598) @(negedge clk);
    run_window(1000, nv, vi);
    check("post_reset_first_valid_cnt", nv, 0);
    check("post_reset_first_duty", duty1, 32768);
    check("post_reset_first_err", err1, 0);
    run_window(1004, nv, vi);
    check("post_reset_second_valid_cnt", nv, 1);
    check("post_reset_second_err", err1, 0);
    check("post_reset_second_duty", duty1, 32768);
    run_window(1000, nv, vi);
    check("post_reset_third_valid_cnt", nv, 1);
    check("post_reset_third_err", err1, 4);
    check("post_reset_third_duty", duty1, 32752);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
